mem_multicycle: RTL and testbench



---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_delay_line.sv | 44 ++++
 rtl/mem_multicycle.sv | 113 +++++++++++
 tb/tb_mem_multicycle.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_pkg                                                  |
// | Description : Shared constants and the response record used by the     |
// |               multi-cycle memory and the cache-fill FSM.               |
// |   MEM_ADDR_WIDTH : byte address width                                  |
// |   MEM_DATA_WIDTH : word width                                          |
// |   MEM_LATENCY    : default read latency in cycles                      |
// |   mem_rsp_t      : {valid, addr, data} response record                 |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_DATA_WIDTH = 16;
    localparam int MEM_LATENCY    = 4;

    typedef struct packed {
        logic                      valid;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] data;
    } mem_rsp_t;

endpackage
`default_nettype wire

// File: rtl/mem_delay_line.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_delay_line                                           |
// | Description : LATENCY-stage shift register of mem_rsp_t records with   |
// |               synchronous clear.                                       |
// |   clk     : rising-edge clock                                          |
// |   rst     : synchronous active-high clear of every stage               |
// |   rsp_in  : record captured into stage 0 each cycle                    |
// |   rsp_out : record held in the last stage (registered)                 |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module mem_delay_line
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY
)
(
    input  logic     clk,
    input  logic     rst,
    input  mem_rsp_t rsp_in,
    output mem_rsp_t rsp_out
);

    mem_rsp_t r_stage [LATENCY];

    // The whole record is cleared, not just valid, so downstream addr/data
    // stay zero whenever valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= rsp_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign rsp_out = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/mem_multicycle.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_multicycle                                           |
// | Description : Word memory with fixed-latency, in-order read responses. |
// |               One request accepted per cycle, no backpressure.         |
// |   clk         : rising-edge clock                                      |
// |   rst         : synchronous active-high reset (storage preserved)      |
// |   enable      : request present this cycle                             |
// |   wr          : 1 = write, 0 = read                                    |
// |   addr        : byte address, bit 0 ignored                            |
// |   data_in     : write data                                             |
// |   data_out    : read data, zero unless data_valid                      |
// |   data_valid  : read response valid                                    |
// |   addr_out    : word-aligned address of the returned read              |
// |   outstanding : reads accepted but not yet returned                    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module mem_multicycle
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int    DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int    DEPTH_WORDS = 32768,
    parameter int    LATENCY     = MEM_LATENCY,
    // Kept for drop-in compatibility; storage starts uninitialised here.
    parameter string INIT_FILE   = ""
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [3:0]            outstanding
);

    localparam int          c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_DEPTH = DEPTH_WORDS;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [3:0]            r_outstanding;

    logic [ADDR_WIDTH-2:0] w_word_addr;
    logic [31:0]           w_idx_full;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_read;
    logic                  w_write;
    mem_rsp_t              w_rsp_in;
    mem_rsp_t              w_rsp_out;

    assign w_word_addr = addr[ADDR_WIDTH-1:1];
    // Modulo in 32 bits so a depth equal to 2**(ADDR_WIDTH-1) cannot
    // truncate to a zero divisor; for power-of-two depths this is a mask.
    assign w_idx_full  = {{(33-ADDR_WIDTH){1'b0}}, w_word_addr} % c_DEPTH;
    assign w_idx       = w_idx_full[c_IDX_W-1:0];

    // Reset gating for reads lives in the delay line: stage 0 is cleared
    // during reset, so a read presented then is dropped.
    assign w_read  = enable & ~wr;
    assign w_write = enable & wr & ~rst;

    logic w_unused;
    assign w_unused = &{1'b0, addr[0], w_idx_full};

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // The read samples storage before this edge's write takes effect;
    // since only one request arrives per cycle, that is every earlier write.
    always_comb begin
        w_rsp_in       = '0;
        w_rsp_in.valid = w_read;
        if (w_read) begin
            w_rsp_in.addr = {w_word_addr, 1'b0};
            w_rsp_in.data = r_mem[w_idx];
        end
    end

    mem_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .rsp_in  (w_rsp_in),
        .rsp_out (w_rsp_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_read, w_rsp_out.valid})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign data_valid  = w_rsp_out.valid;
    assign data_out    = w_rsp_out.data;
    assign addr_out    = w_rsp_out.addr;
    assign outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_mem_multicycle.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mem_multicycle                                        |
// | Description : Randomised and directed scoreboard bench for             |
// |               mem_multicycle.                                          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_mem_multicycle;

    localparam int LAT   = 4;
    localparam int DEPTH = 4096;   // small enough that 16-bit addresses wrap

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [15:0] addr_out;
    logic [3:0]  outstanding;

    mem_multicycle #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr          (wr),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .addr_out    (addr_out),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          exp_cyc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model [int];
    int          cyc     = 0;
    int          passed  = 0;
    int          total   = 0;
    int          max_out = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Inputs applied at the falling edge are accepted at the next rising
    // edge, which makes cyc equal to cyc_now+1; the response is then
    // visible after the rising edge where cyc reaches cyc_now+LAT.
    task automatic drive(input bit r, input bit en, input bit w,
                         input logic [15:0] a, input logic [15:0] d);
        int   idx;
        exp_t e;
        @(negedge clk);
        rst     = r;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        idx     = (int'(a) >> 1) % DEPTH;
        if (r) begin
            q.delete();
        end else if (en) begin
            if (w) begin
                model[idx] = d;
            end else begin
                e.addr    = {a[15:1], 1'b0};
                e.data    = model.exists(idx) ? model[idx] : 16'h0000;
                e.exp_cyc = cyc + LAT;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Monitor: compares after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("outstanding", {28'd0, outstanding}, q.size());
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
            if (data_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", {31'd0, data_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc, e.exp_cyc);
                    check("data_out", {16'd0, data_out}, {16'd0, e.data});
                    check("addr_out", {16'd0, addr_out}, {16'd0, e.addr});
                end
            end else begin
                check("idle_outputs_zero", {data_out, addr_out}, 32'd0);
                if (q.size() > 0 && q[0].exp_cyc <= cyc) begin
                    check("missing_valid", {31'd0, data_valid}, 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int          waited;
        logic [15:0] a;

        // Reset for two cycles with a live write presented (must be ignored),
        // then ten idle cycles.
        drive(1'b1, 1'b1, 1'b1, 16'h0010, 16'hDEAD);
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(10);

        // Write then read on the next cycle.
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(LAT + 2);

        // Streaming: 8 writes then 8 back-to-back reads.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 1'b1, 16'(2*i), 16'(2*i + 16'h0100));
        max_out = 0;
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 1'b0, 16'(2*i), 16'h0000);
        idle(LAT + 2);
        check("peak_outstanding", max_out, LAT);

        // Snapshot ordering: a read in flight ignores a later write.
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111);
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222);
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(LAT + 2);

        // Reset mid-flight: in-flight reads dropped, requests during reset
        // ignored, storage survives.
        drive(1'b0, 1'b1, 1'b1, 16'h0040, 16'h4444);
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 16'h0040, 16'h9999);
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(LAT + 4);
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        idle(LAT + 2);

        // Odd-address alias and wrap past the storage depth.
        drive(1'b0, 1'b1, 1'b1, 16'h0031, 16'h3131);
        drive(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h2031, 16'h0000);
        drive(1'b0, 1'b1, 1'b1, 16'h4052, 16'h5252);
        drive(1'b0, 1'b1, 1'b0, 16'h0052, 16'h0000);
        idle(LAT + 2);

        // Randomised traffic over a pre-written pool with aliasing high bits.
        for (int i = 0; i < 32; i++)
            drive(1'b0, 1'b1, 1'b1, 16'(16'h0100 + 2*i), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            a = 16'(16'h0100 + 2*$urandom_range(0, 31) + $urandom_range(0, 1)
                    + 8192*$urandom_range(0, 7));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, a, 16'($urandom));
        end

        // Drain with a bounded wait.
        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        idle(2);
        check("drain_complete", q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
